// File: rtl/prio_grant_decoder.sv
// Sequential decoder for the 4-request priority encoder's 3-bit code.
// Holds a one-hot grant until ack or timeout, then inserts a release gap.
module prio_grant_decoder #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] code,
    input  logic       code_valid,
    input  logic [4:1] ack,
    output logic       ready,
    output logic [4:1] grant,
    output logic [2:0] cur_code,
    output logic       done,
    output logic       timeout,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [4:1] grant_q;
    logic [2:0] cur_code_q;
    logic       done_q;
    logic       timeout_q;
    logic       err_q;

    logic [4:1] code_oh;
    logic       code_ill;
    logic       accept;
    logic       ack_hit;
    logic       cnt_last;

    always_comb begin
        code_oh  = 4'b0000;
        code_ill = 1'b0;
        case (code)
            3'd0:    code_oh = 4'b0000;
            3'd1:    code_oh = 4'b0001;
            3'd2:    code_oh = 4'b0010;
            3'd3:    code_oh = 4'b0100;
            3'd4:    code_oh = 4'b1000;
            default: code_ill = 1'b1;
        endcase
    end

    assign ready    = (state_q == IDLE);
    assign accept   = code_valid && ready;
    // grant_q is one-hot of cur_code while in GRANT, so this
    // picks out ack[cur_code] and ignores the other lines.
    assign ack_hit  = |(ack & grant_q);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            grant_q    <= 4'b0000;
            cur_code_q <= 3'd0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (code_oh != 4'b0000) begin
                            grant_q    <= code_oh;
                            cur_code_q <= code;
                            cnt_q      <= 8'd0;
                            state_q    <= GRANT;
                        end else if (code_ill) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    // ack takes precedence over an expiring count
                    if (ack_hit) begin
                        grant_q <= 4'b0000;
                        done_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= RELEASE;
                    end else if (cnt_last) begin
                        grant_q   <= 4'b0000;
                        timeout_q <= 1'b1;
                        cnt_q     <= 8'd0;
                        state_q   <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= 4'b0000;
                    cnt_q   <= 8'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign cur_code = cur_code_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign err      = err_q;

endmodule

// File: doc/prio_grant_decoder.md
# prio_grant_decoder

Sequential decoder for the 3-bit priority code produced by the team's 4-request priority encoder. It accepts a code with a valid/ready handshake and asserts the matching one-hot grant line (r4..r1 numbering). It holds the grant until the requester acknowledges or a timeout expires, then enforces a one-cycle release gap. It sits on the arbiter side, between the encoder output and the four requesting agents.

## Interface
- TIMEOUT, 16, maximum cycles a grant is held without ack; legal range 2..255
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- code  input  3  priority code: 3'b100=line 4, 3'b011=line 3, 3'b010=line 2, 3'b001=line 1, 3'b000=no request, 3'b101..3'b111 illegal
- code_valid  input  1  code is valid this cycle
- ack  input  4 [4:1]  per-line release acknowledge from requesters
- ready  output  1  block can accept a code (high only in IDLE)
- grant  output  4 [4:1]  registered one-hot grant, or all zero
- cur_code  output  3  registered code of the current or last accepted grant
- done  output  1  one-cycle pulse: grant released by ack
- timeout  output  1  one-cycle pulse: grant released by timeout
- err  output  1  one-cycle pulse: illegal code accepted

## Operation
- States: IDLE, GRANT, RELEASE. The 8-bit counter cnt is used only in GRANT.
- A code is accepted on a rising edge where code_valid=1 and ready=1. code_valid is ignored when ready=0 (no queuing).
- ready is combinational: ready = (state==IDLE).
- IDLE, accepted code 1..4: set grant to one-hot bit [code], set cur_code=code, set cnt=0, go to GRANT.
- IDLE, accepted code 0: no state change and no pulse; grant stays 0.
- IDLE, accepted code 5..7: pulse err for one cycle; stay in IDLE; grant and cur_code unchanged.
- GRANT: only ack[cur_code] is examined. ack on any other line is ignored.
  - ack[cur_code]=1 at an edge: clear grant, pulse done, go to RELEASE.
  - Otherwise, if cnt==TIMEOUT-1: clear grant, pulse timeout, go to RELEASE.
  - Otherwise: cnt increments.
- Ack and the timeout limit in the same cycle: ack wins. done=1 and timeout=0.
- RELEASE: grant=0 and ready=0 for exactly one cycle, then go to IDLE unconditionally.
- done, timeout and err are never high together. Each is high for exactly one cycle.
- cur_code holds its value through RELEASE and IDLE until the next legal nonzero accept.

## Timing
- Reset (asynchronous, immediate) forces:
  - state=IDLE, grant=4'b0000, cur_code=3'b000, done=0, timeout=0, err=0, cnt=0
  - ready=1 while reset is held and after reset is released
- Reset asserted mid-GRANT drops grant in the same cycle, without waiting for a clock edge. No done or timeout pulse is generated.
- Accept latency: a code accepted at edge k gives grant visible after edge k. The first GRANT cycle is k..k+1.
- Without ack, grant is high for exactly TIMEOUT cycles. timeout is high in the cycle after the last grant cycle, coincident with RELEASE.
- With ack high in the n-th grant cycle (n counted from 1), grant is high for n cycles. done is high in the following cycle.
- err is high in the cycle after the accepting edge.
- Minimum spacing between two grants: accept edge, ≥1 GRANT cycle, 1 RELEASE cycle, then 1 IDLE cycle to accept. Back-to-back grants are therefore separated by ≥2 cycles with grant=0.
- All outputs except ready are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, then code=3'b011 with code_valid=1 for one edge, ack[3]=1 in the 3rd grant cycle:
  - grant=4'b0100 for 3 cycles
  - then done=1 for 1 cycle, grant=0, ready=0 for 1 cycle, then ready=1
  - cur_code=3'b011 throughout
- TIMEOUT=4, code=3'b100, no ack:
  - grant=4'b1000 for exactly 4 cycles
  - timeout=1 for 1 cycle, done stays 0
- code=3'b001 granted, ack=4'b1110 held:
  - grant=4'b0001 stays high through timeout; ack on other lines has no effect
  - repeat with ack[1] and the timeout limit in the same cycle: done=1, timeout=0
- code=3'b110 accepted in IDLE: err=1 for 1 cycle, grant=0, ready stays 1, cur_code unchanged. code=3'b000 accepted: no pulse and no grant.
- code_valid held high with code=3'b010 continuously, ack[2] pulsed every grant: grants separated by ≥2 zero cycles, ready low throughout GRANT and RELEASE.
- Reset asserted mid-GRANT, between clock edges: grant=0 and cur_code=0 immediately; after release ready=1, and the next code is accepted normally.
